// File: rtl/conv_pe_array_256_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_array_256_if
// Description : Operand/result bundle for the 256-PE MAC array. The master
//               side drives IFM, Weight and the per-PE restart/finish bits.
//               The slave side (the PE array) returns OFM and valid.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_pe_array_256_if #(
  parameter int NUM_OF_PE = 256,
  parameter int DATA_W    = 8
);
  logic [NUM_OF_PE*DATA_W-1:0] IFM;
  logic [DATA_W-1:0]           Weight;
  logic [NUM_OF_PE-1:0]        PE_restart;
  logic [NUM_OF_PE-1:0]        PE_finish;
  logic [NUM_OF_PE*DATA_W-1:0] OFM;
  logic [NUM_OF_PE-1:0]        valid;

  modport master (
    output IFM, Weight, PE_restart, PE_finish,
    input  OFM, valid
  );

  modport slave (
    input  IFM, Weight, PE_restart, PE_finish,
    output OFM, valid
  );
endinterface
`default_nettype wire

// File: rtl/conv_pe_array_256.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_array_256
// Description : 256 independent signed 8x8 multiply-accumulate PEs sharing
//               one broadcast weight. Each PE has a 24-bit wrapping
//               accumulator, per-PE restart/finish control and an 8-bit
//               saturated result.
//               Optional macro CONV_PE_RELU_EN: negative accumulators map
//               to OFM = 0 instead of saturating to -128.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pe_array_256 #(
  parameter int NUM_OF_PE = 256,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  conv_pe_array_256_if.slave  bus
);

  localparam int               c_prod_w   = 2 * DATA_W;
  localparam logic [ACC_W-1:0] c_sat_max  = ACC_W'((1 << (DATA_W - 1)) - 1);
  // Bitwise inverse of +max is -max-1, the most negative representable byte.
  localparam logic [ACC_W-1:0] c_sat_min  = ~c_sat_max;
  localparam logic [DATA_W-1:0] c_ofm_max = c_sat_max[DATA_W-1:0];
  localparam logic [DATA_W-1:0] c_ofm_min = c_sat_min[DATA_W-1:0];

  for (genvar k = 0; k < NUM_OF_PE; k++) begin : g_pe
    logic signed [c_prod_w-1:0] w_prod;
    logic [ACC_W-1:0]           w_prod_ext;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       hold_q, hold_d;
    logic                       valid_q, valid_d;
    logic                       w_above;
    logic                       w_below;
    logic [DATA_W-1:0]          w_ofm;

    assign w_prod     = $signed(bus.IFM[k*DATA_W +: DATA_W]) * $signed(bus.Weight);
    assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

    // Next-state: restart beats finish, finish freezes, otherwise accumulate unless held.
    always_comb begin
      acc_d   = acc_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      if (bus.PE_restart[k]) begin
        acc_d   = w_prod_ext;
        hold_d  = 1'b0;
        valid_d = 1'b0;
      end else if (bus.PE_finish[k]) begin
        hold_d  = 1'b1;
        valid_d = 1'b1;
      end else if (!hold_q) begin
        acc_d   = acc_q + w_prod_ext;
      end
    end

    // PE state registers; reset discards any partial window immediately.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q   <= '0;
        hold_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        hold_q  <= hold_d;
        valid_q <= valid_d;
      end
    end

    assign w_above = $signed(acc_q) > $signed(c_sat_max);
    assign w_below = $signed(acc_q) < $signed(c_sat_min);

    // Map the wide accumulator onto the 8-bit result; the accumulator itself is never clipped.
    always_comb begin
      w_ofm = acc_q[DATA_W-1:0];
`ifdef CONV_PE_RELU_EN
      if (acc_q[ACC_W-1]) begin
        w_ofm = '0;
      end else if (w_above) begin
        w_ofm = c_ofm_max;
      end
      if (w_below) begin
        w_ofm = '0;
      end
`else
      if (w_above) begin
        w_ofm = c_ofm_max;
      end else if (w_below) begin
        w_ofm = c_ofm_min;
      end
`endif
    end

    assign bus.OFM[k*DATA_W +: DATA_W] = w_ofm;
    assign bus.valid[k]                = valid_q;
  end : g_pe

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_array_256.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_array_256
// Description : Randomized self-checking bench for conv_pe_array_256 with an
//               integer-arithmetic reference model of every PE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pe_array_256;
  localparam int NPE = 256;
  localparam int DW  = 8;

  logic clk;
  logic reset_n;

  conv_pe_array_256_if #(.NUM_OF_PE(NPE), .DATA_W(DW)) bus ();

  conv_pe_array_256 #(.NUM_OF_PE(NPE), .DATA_W(DW), .ACC_W(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus held by the bench and copied onto the interface each cycle.
  logic [NPE*DW-1:0] ifm_v;
  logic [DW-1:0]     w_v;
  logic [NPE-1:0]    rst_v;
  logic [NPE-1:0]    fin_v;

  // Reference model: plain integers per PE.
  int m_acc   [NPE];
  bit m_hold  [NPE];
  bit m_valid [NPE];

  int n_total;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap24(input int v);
    int t;
    t = v & 32'h00FF_FFFF;
    if (t >= 32'h0080_0000) t = t - 32'h0100_0000;
    return t;
  endfunction

  function automatic logic [7:0] exp_ofm(input int a);
    int t;
    t = a;
`ifdef CONV_PE_RELU_EN
    if (t < 0)   return 8'h00;
    if (t > 127) return 8'h7F;
`else
    if (t > 127)  return 8'h7F;
    if (t < -128) return 8'h80;
`endif
    return t[7:0];
  endfunction

  function automatic int ifm_of(input int k);
    logic [7:0] b;
    b = ifm_v[k*DW +: DW];
    return int'($signed(b));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NPE; k++) begin
      m_acc[k] = 0; m_hold[k] = 0; m_valid[k] = 0;
    end
  endtask

  task automatic model_edge();
    int p;
    for (int k = 0; k < NPE; k++) begin
      p = ifm_of(k) * int'($signed(w_v));
      if (rst_v[k]) begin
        m_acc[k] = p; m_hold[k] = 0; m_valid[k] = 0;
      end else if (fin_v[k]) begin
        m_hold[k] = 1; m_valid[k] = 1;
      end else if (!m_hold[k]) begin
        m_acc[k] = wrap24(m_acc[k] + p);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NPE; k++) begin
      check($sformatf("ofm%0d", k), 32'(bus.OFM[k*DW +: DW]), 32'(exp_ofm(m_acc[k])));
      check($sformatf("valid%0d", k), 32'(bus.valid[k]), 32'(m_valid[k]));
    end
  endtask

  task automatic rand_ifm();
    for (int k = 0; k < NPE; k++) ifm_v[k*DW +: DW] = 8'($urandom);
  endtask

  task automatic fill_ifm(input logic [7:0] v);
    for (int k = 0; k < NPE; k++) ifm_v[k*DW +: DW] = v;
  endtask

  // Drive, clock once, update the model, then check 1 time unit after the edge.
  task automatic step();
    bus.IFM        = ifm_v;
    bus.Weight     = w_v;
    bus.PE_restart = rst_v;
    bus.PE_finish  = fin_v;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic window(input int len);
    for (int c = 0; c < len; c++) begin
      rand_ifm();
      w_v   = 8'($urandom);
      rst_v = (c == 0) ? '1 : '0;
      fin_v = '0;
      step();
    end
  endtask

  int frozen5;

  initial begin
    n_total = 0;
    n_bad   = 0;
    model_clear();
    reset_n = 1'b0;
    rst_v = '0; fin_v = '0;

    // Reset held with random operands: everything stays zero.
    for (int c = 0; c < 3; c++) begin
      rand_ifm(); w_v = 8'($urandom);
      step();
    end
    reset_n = 1'b1;
    rand_ifm(); w_v = 8'($urandom);
    step();
    check("pe0_first", 32'(bus.OFM[7:0]), 32'(exp_ofm(ifm_of(0) * int'($signed(w_v)))));

    // 27-cycle all-ones window.
    for (int c = 0; c < 27; c++) begin
      fill_ifm(8'h01); w_v = 8'h01;
      rst_v = (c == 0) ? '1 : '0; fin_v = '0;
      step();
    end
    check("acc27_pe0", 32'(bus.OFM[7:0]), 32'h1B);
    check("acc27_pe255", 32'(bus.OFM[255*DW +: DW]), 32'h1B);

    // Positive saturation.
    for (int c = 0; c < 2; c++) begin
      fill_ifm(8'h7F); w_v = 8'h7F;
      rst_v = (c == 0) ? '1 : '0; fin_v = '0;
      step();
    end
    check("sat_pos", 32'(bus.OFM[7:0]), 32'h7F);

    // Negative saturation (or ReLU clamp).
    for (int c = 0; c < 2; c++) begin
      fill_ifm(8'h7F); w_v = 8'h80;
      rst_v = (c == 0) ? '1 : '0; fin_v = '0;
      step();
    end
`ifdef CONV_PE_RELU_EN
    check("sat_neg", 32'(bus.OFM[7:0]), 32'h00);
`else
    check("sat_neg", 32'(bus.OFM[7:0]), 32'h80);
`endif

    // Finish on PE5 after 9 accumulating cycles; others continue.
    window(9);
    rand_ifm(); w_v = 8'($urandom); rst_v = '0; fin_v = '0; fin_v[5] = 1'b1;
    step();
    frozen5 = m_acc[5];
    check("fin_valid5", 32'(bus.valid[5]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      rand_ifm(); w_v = 8'($urandom); rst_v = '0; fin_v = '0;
      step();
    end
    check("fin_frozen5", 32'(bus.OFM[5*DW +: DW]), 32'(exp_ofm(frozen5)));
    check("fin_valid5_hold", 32'(bus.valid[5]), 32'd1);

    // Restart and finish together on PE3: restart wins.
    rand_ifm(); ifm_v[3*DW +: DW] = 8'd2; w_v = 8'd3;
    rst_v = '0; fin_v = '0; rst_v[3] = 1'b1; fin_v[3] = 1'b1;
    step();
    check("prio_ofm3", 32'(bus.OFM[3*DW +: DW]), 32'h06);
    check("prio_valid3", 32'(bus.valid[3]), 32'd0);

    // Back-to-back windows, with finish at the end of each.
    for (int wdw = 0; wdw < 3; wdw++) begin
      window(27);
      rand_ifm(); rst_v = '0; fin_v = '1;
      step();
    end

    // Random per-PE control, including held restarts.
    for (int c = 0; c < 60; c++) begin
      rand_ifm(); w_v = 8'($urandom);
      for (int k = 0; k < NPE; k++) begin
        rst_v[k] = ($urandom_range(0, 11) == 0);
        fin_v[k] = ($urandom_range(0, 11) == 0);
      end
      step();
    end

    // Asynchronous reset mid-window clears without waiting for an edge.
    window(5);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all();
    window(2);
    reset_n = 1'b1;
    window(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_pe_array_256.md
# conv_pe_array_256

Array of 256 independent multiply-accumulate processing elements (PEs) for the convolution engine of the fused-block CNN datapath. Each cycle, one shared 8-bit weight is broadcast to all PEs, and each PE gets its own 8-bit input-feature-map byte. Each PE accumulates the products over a kernel window (for example 3x3x3 = 27 cycles). Each PE exposes a saturated 8-bit result, with per-PE restart, finish and valid control.

## Interface
- NUM_OF_PE, 256, number of PEs; sets the width of the IFM, OFM and per-PE vectors.
- DATA_W, 8, width of IFM element, weight and OFM element.
- ACC_W, 24, accumulator width per PE.
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- IFM  input  NUM_OF_PE*DATA_W  PE k operand at bits [k*8 +: 8], signed two's complement.
- Weight  input  DATA_W  signed weight, broadcast to all PEs.
- PE_restart  input  NUM_OF_PE  per-PE start of a new accumulation window.
- PE_finish  input  NUM_OF_PE  per-PE end of window; freezes the accumulator and raises valid.
- OFM  output  NUM_OF_PE*DATA_W  PE k result at bits [k*8 +: 8], signed saturated.
- valid  output  NUM_OF_PE  per-PE result-final flag.

## Operation
- Product per PE: p_k = signed(IFM[k]) * signed(Weight), 16-bit, sign-extended to ACC_W.
- Per-PE state: acc_k (ACC_W bits), hold_k (1 bit), valid_k (1 bit). Update priority at each rising edge:
  - PE_restart[k]=1: acc_k <= p_k (the first product of the new window is loaded, not lost); hold_k <= 0; valid_k <= 0.
  - Else PE_finish[k]=1: acc_k unchanged; hold_k <= 1; valid_k <= 1.
  - Else hold_k=0: acc_k <= acc_k + p_k, wrapping modulo 2^ACC_W.
  - Else (holding): no change.
- With restart and finish never asserted, every PE accumulates on every cycle.
- OFM[k] is a combinational function of acc_k:
  - +127 if acc_k > 127;
  - -128 if acc_k < -128;
  - otherwise acc_k[7:0].
- The PEs are fully independent; the control bits can differ per PE.

## Timing
- Reset (asynchronous assert, synchronous release): acc_k=0, hold_k=0, valid_k=0, so OFM=0 and valid=0.
- Inputs are sampled at the rising edge.
- acc_k includes the product sampled at edge n immediately after edge n, so OFM has one cycle of latency from operand to result.
- valid rises on the edge that samples PE_finish and stays high until restart or reset.
- Restart and finish asserted together: restart wins.
- Reset mid-window: acc_k clears at once, and the window's partial sum is discarded.
- A restart held for several cycles reloads acc_k with the current product each cycle.
- Accumulator overflow wraps silently; saturation applies only at OFM.
- No handshake, backpressure or stall: the producer must present one valid operand pair per cycle while accumulating.

## Configuration
- CONV_PE_RELU_EN defined: OFM[k] = 0 whenever acc_k < 0; positive values saturate at +127.
- Undefined: signed saturation to [-128, +127] as described under Operation.
- The accumulator contents are identical in both builds; only the OFM mapping differs.

## Test plan
- Reset: hold reset_n=0 with random IFM/Weight -> OFM=0 and valid=0 for all PEs; after release, OFM of PE0 equals IFM0*Weight sampled at the first edge, saturated.
- Accumulation: 27 cycles, Weight=1, IFM[k]=1 for all k, restart on the first cycle -> every OFM byte = 0x1B, valid=0.
- Saturation: Weight=0x7F (+127), IFM=0x7F, 2 cycles -> OFM=0x7F. Weight=0x80 (-128), IFM=0x7F -> OFM=0x80, or 0x00 with CONV_PE_RELU_EN.
- Finish/hold: pulse PE_finish[5] after 9 cycles, keep driving data -> OFM[5] frozen and valid[5]=1 from that edge; other PEs keep accumulating.
- Restart priority: assert PE_restart and PE_finish together on PE3 with IFM3=2, Weight=3 -> acc=6, OFM[3]=0x06, valid[3]=0.
- Back-to-back tiles: repeat 27-cycle windows with a restart on the first cycle of each -> each window's OFM equals that window's dot product only, with no carry-over from the previous window.
